// File: rtl/dbg_trace_pkg.sv
// Shared constants for the debug trace block: CSR map, register bit positions
// and trace entry field layout.
package dbg_trace_pkg;

  localparam int unsigned BUS_W  = 64;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned SEQ_W  = 7;
  localparam int unsigned DROP_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_TRACE   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PART_EN = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 2'd3;

  localparam int unsigned CTRL_CAPTURE_EN = 0;
  localparam int unsigned CTRL_MODE       = 1;
  localparam int unsigned CTRL_FLUSH      = 2;
  localparam int unsigned CTRL_CLR_OVF    = 3;

  localparam int unsigned STAT_CNT_W    = 16;
  localparam int unsigned STAT_EMPTY    = 16;
  localparam int unsigned STAT_FULL     = 17;
  localparam int unsigned STAT_OVF      = 18;
  localparam int unsigned STAT_DROP_LSB = 32;

  localparam int unsigned ENTRY_VALID = 63;

  typedef struct packed {
    logic mode;
    logic capture_en;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{mode: 1'b0, capture_en: 1'b1};

  // Entry layout from the LSB: debug sample, timestamp, sequence number.
  function automatic int unsigned ts_lsb(input int unsigned dbg_w);
    return dbg_w;
  endfunction

  function automatic int unsigned seq_lsb(input int unsigned dbg_w, input int unsigned ts_w);
    return dbg_w + ts_w;
  endfunction

endpackage

// File: rtl/debug_trace_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module debug_trace_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign head_c  = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    pop_ok   = pop && !empty_c;
    push_ok  = push && (!full_c || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible below count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/writing_address_debug_trace.sv
// Debug-bus change tracer with an Avalon-MM CSR window and partition
// write-enable register, polled by the host through the debug bridge.
module writing_address_debug_trace
  import dbg_trace_pkg::*;
#(
  parameter int unsigned DBG_W  = 8,
  parameter int unsigned N_PART = 5,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_Avalon_address,
  input  logic              io_Avalon_read,
  output logic [BUS_W-1:0]  io_Avalon_readdata,
  input  logic              io_Avalon_write,
  input  logic [BUS_W-1:0]  io_Avalon_writedata,
  output logic              io_Avalon_waitrequest,
  output logic [N_PART-1:0] io_PartitionWriteEnables,
  input  logic [DBG_W-1:0]  io___dbgInfo
);

  localparam int unsigned TS_LSB  = ts_lsb(DBG_W);
  localparam int unsigned SEQ_LSB = seq_lsb(DBG_W, TS_W);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DBG_W-1:0]  prev_dbg_q, prev_dbg_d;
  logic [N_PART-1:0] part_en_q, part_en_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  ctrl_t             ctrl_q, ctrl_d;

  logic              capture, push, pop, flush, clr_ovf, accept, drop, ctrl_wr;
  logic [BUS_W-1:0]  entry, head, status;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic              unused_wdata;

  assign unused_wdata          = &{1'b0, io_Avalon_writedata};
  assign io_Avalon_waitrequest = 1'b0;
  assign io_PartitionWriteEnables = part_en_q;

  debug_trace_fifo #(.W(BUS_W), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (entry),
    .head_c  (head),
    .count   (count),
    .full_c  (full),
    .empty_c (empty)
  );

  always_comb begin
    entry                       = '0;
    entry[ENTRY_VALID]          = 1'b1;
    entry[SEQ_LSB +: SEQ_W]     = seq_q;
    entry[TS_LSB +: TS_W]       = ts_q;
    entry[DBG_W-1:0]            = io___dbgInfo;
  end

  // Capture, CSR writes and counter updates.
  always_comb begin
    capture    = ctrl_q.capture_en && (ctrl_q.mode || (io___dbgInfo != prev_dbg_q));
    ctrl_wr    = io_Avalon_write && (io_Avalon_address == ADDR_CTRL);
    flush      = ctrl_wr && io_Avalon_writedata[CTRL_FLUSH];
    clr_ovf    = ctrl_wr && io_Avalon_writedata[CTRL_CLR_OVF];
    pop        = io_Avalon_read && (io_Avalon_address == ADDR_TRACE) && !empty;
    push       = capture && !flush;
    accept     = push && (!full || pop);
    drop       = push && full && !pop;

    ts_d       = ts_q + TS_W'(1);
    seq_d      = accept ? seq_q + SEQ_W'(1) : seq_q;
    prev_dbg_d = (capture && !ctrl_q.mode) ? io___dbgInfo : prev_dbg_q;

    part_en_d  = part_en_q;
    if (io_Avalon_write && (io_Avalon_address == ADDR_PART_EN)) begin
      part_en_d = io_Avalon_writedata[N_PART-1:0];
    end

    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d.capture_en = io_Avalon_writedata[CTRL_CAPTURE_EN];
      ctrl_d.mode       = io_Avalon_writedata[CTRL_MODE];
    end

    // A drop in the clearing cycle survives the clear.
    overflow_d = (overflow_q && !clr_ovf) || drop;
    drop_cnt_d = clr_ovf ? '0 : drop_cnt_q;
    if (drop && (drop_cnt_d != '1)) begin
      drop_cnt_d = drop_cnt_d + DROP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q       <= '0;
      seq_q      <= '0;
      prev_dbg_q <= '0;
      part_en_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      ctrl_q     <= CTRL_RST;
    end else begin
      ts_q       <= ts_d;
      seq_q      <= seq_d;
      prev_dbg_q <= prev_dbg_d;
      part_en_q  <= part_en_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_comb begin
    status                            = '0;
    status[STAT_CNT_W-1:0]            = STAT_CNT_W'(count);
    status[STAT_EMPTY]                = empty;
    status[STAT_FULL]                 = full;
    status[STAT_OVF]                  = overflow_q;
    status[STAT_DROP_LSB +: DROP_W]   = drop_cnt_q;
  end

  // Zero-latency read mux; an empty trace FIFO reads as all zeros.
  always_comb begin
    io_Avalon_readdata = '0;
    case (io_Avalon_address)
      ADDR_TRACE:   io_Avalon_readdata = empty ? '0 : head;
      ADDR_PART_EN: io_Avalon_readdata = BUS_W'(part_en_q);
      ADDR_STATUS:  io_Avalon_readdata = status;
      ADDR_CTRL:    io_Avalon_readdata = BUS_W'(ctrl_q);
      default:      io_Avalon_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_writing_address_debug_trace.sv
// Directed bench with a queue-based reference model checked every cycle.
module tb_writing_address_debug_trace;

  localparam int unsigned DBG_W  = 8;
  localparam int unsigned N_PART = 5;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TS_W   = 24;

  logic        clock, reset;
  logic [1:0]  addr;
  logic        rd, wr;
  logic [63:0] wd, rdata;
  logic        wreq;
  logic [4:0]  pwe;
  logic [7:0]  dbg;

  writing_address_debug_trace #(.DBG_W(DBG_W), .N_PART(N_PART), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_Avalon_address        (addr),
    .io_Avalon_read           (rd),
    .io_Avalon_readdata       (rdata),
    .io_Avalon_write          (wr),
    .io_Avalon_writedata      (wd),
    .io_Avalon_waitrequest    (wreq),
    .io_PartitionWriteEnables (pwe),
    .io___dbgInfo             (dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: trace FIFO as a queue of {seq, ts, dbg} records.
  typedef struct {
    logic [6:0]  seq;
    logic [23:0] ts;
    logic [7:0]  dbg;
  } ent_t;

  ent_t        mq[$];
  logic [23:0] m_ts;
  logic [6:0]  m_seq;
  logic [7:0]  m_prev;
  logic [4:0]  m_part;
  logic        m_ovf, m_cap_en, m_mode;
  logic [31:0] m_drop;
  bit          m_ok = 0;

  function automatic logic [63:0] model_rdata(input logic [1:0] a);
    logic [15:0] n;
    n = 16'(mq.size());
    case (a)
      2'd0:    return (mq.size() == 0) ? 64'd0 : {1'b1, 24'd0, mq[0].seq, mq[0].ts, mq[0].dbg};
      2'd1:    return {59'd0, m_part};
      2'd2:    return {m_drop, 13'd0, m_ovf, (n == 16'(DEPTH)), (n == 16'd0), n};
      default: return {62'd0, m_mode, m_cap_en};
    endcase
  endfunction

  task automatic model_step();
    bit   pop, flush, cap;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_ts = '0; m_seq = '0; m_prev = '0; m_part = '0;
      m_ovf = 1'b0; m_drop = '0; m_cap_en = 1'b1; m_mode = 1'b0;
      m_ok = 1;
      return;
    end
    pop   = rd && (addr == 2'd0) && (mq.size() > 0);
    flush = wr && (addr == 2'd3) && wd[2];
    cap   = m_cap_en && (m_mode || (dbg != m_prev));
    e     = '{m_seq, m_ts, dbg};
    if (cap && !m_mode) m_prev = dbg;
    if (wr && (addr == 2'd3) && wd[3]) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(e);
          m_seq++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 32'hFFFF_FFFF) m_drop++;
        end
      end
    end
    if (wr && (addr == 2'd1)) m_part = wd[4:0];
    if (wr && (addr == 2'd3)) begin
      m_cap_en = wd[0];
      m_mode   = wd[1];
    end
    m_ts++;
  endtask

  // Compare mid-cycle, then advance the model to the coming edge.
  always @(negedge clock) begin
    if (m_ok) begin
      check("readdata", rdata, model_rdata(addr));
      check("part_en", 64'(pwe), 64'(m_part));
      check("waitrequest", 64'(wreq), 64'd0);
    end
    model_step();
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [63:0] v);
    addr = a; rd = 1'b1;
    #3 v = rdata;
    tick();
    rd = 1'b0; addr = 2'd2;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [63:0] d);
    addr = a; wr = 1'b1; wd = d;
    tick();
    wr = 1'b0; wd = '0; addr = 2'd2;
  endtask

  logic [63:0] v, a, b, c;

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = 2'd2; wd = '0; dbg = 8'h00;
    tick(); tick();
    reset = 1'b0;

    // Reset state and two captured changes
    do_read(2'd2, v); check("t1 reset status", v, 64'h0000_0000_0001_0000);
    do_read(2'd3, v); check("t1 reset ctrl", v, 64'd1);
    do_read(2'd1, v); check("t1 reset part_en", v, 64'd0);
    repeat (10) tick();
    dbg = 8'h05;
    repeat (10) tick();
    dbg = 8'h09;
    tick(); tick();
    do_read(2'd2, v); check("t1 count", 64'(v[15:0]), 64'd2);
    do_read(2'd0, a); do_read(2'd0, b); do_read(2'd0, c);
    check("t1 e0 valid", 64'(a[63]), 64'd1);
    check("t1 e0 seq", 64'(a[38:32]), 64'd0);
    check("t1 e0 dbg", 64'(a[7:0]), 64'h05);
    check("t1 e1 seq", 64'(b[38:32]), 64'd1);
    check("t1 e1 dbg", 64'(b[7:0]), 64'h09);
    check("t1 ts delta", 64'(b[31:8] - a[31:8]), 64'd10);
    check("t1 empty read", c, 64'd0);

    // Overflow: 20 changes into a 16-deep FIFO
    reset = 1'b1; dbg = 8'h00; tick(); reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dbg = 8'(8'h10 + i);
      tick();
    end
    do_read(2'd2, v); check("t2 status full", v, 64'h0000_0004_0006_0010);
    do_write(2'd3, 64'h9);
    do_read(2'd2, v); check("t2 status cleared", v, 64'h0000_0000_0002_0010);

    // Pop and push on a full FIFO in the same cycle
    addr = 2'd0; rd = 1'b1; dbg = 8'h77;
    #3 v = rdata;
    tick();
    rd = 1'b0; addr = 2'd2;
    check("t3 popped seq", 64'(v[38:32]), 64'd0);
    check("t3 popped dbg", 64'(v[7:0]), 64'h10);
    do_read(2'd2, v); check("t3 count kept", v, 64'h0000_0000_0002_0010);
    for (int i = 0; i < 16; i++) begin
      do_read(2'd0, v);
      if (i == 0) check("t3 next seq", 64'(v[38:32]), 64'd1);
      if (i == 15) begin
        check("t3 tail seq", 64'(v[38:32]), 64'd16);
        check("t3 tail dbg", 64'(v[7:0]), 64'h77);
      end
    end
    do_read(2'd2, v); check("t3 drained", v, 64'h0000_0000_0001_0000);

    // Partition enables
    do_write(2'd1, 64'h15);
    check("t4 enables", 64'(pwe), 64'h15);
    do_read(2'd1, v); check("t4 read part_en", v, 64'h15);
    do_write(2'd1, 64'hFFE0);
    check("t4 enables upper ignored", 64'(pwe), 64'h00);

    // Every-cycle mode, capture disable, flush
    do_write(2'd3, 64'h3);
    tick(); tick();
    do_write(2'd3, 64'h0);
    repeat (3) tick();
    do_read(2'd2, v); check("t5 count 3", v, 64'h0000_0000_0000_0003);
    do_read(2'd0, a); do_read(2'd0, b); do_read(2'd0, c);
    check("t5 seq a", 64'(a[38:32]), 64'd17);
    check("t5 seq c", 64'(c[38:32]), 64'd19);
    check("t5 ts consecutive", 64'(b[31:8] - a[31:8]), 64'd1);
    check("t5 ts consecutive 2", 64'(c[31:8] - b[31:8]), 64'd1);
    do_write(2'd3, 64'h3);
    tick();
    do_write(2'd3, 64'h4);
    do_read(2'd2, v); check("t5 flushed", v, 64'h0000_0000_0001_0000);
    do_write(2'd3, 64'h1);
    dbg = 8'h42;
    tick();
    do_read(2'd0, v);
    check("t5 seq after flush", 64'(v[38:32]), 64'd21);
    check("t5 dbg after flush", 64'(v[7:0]), 64'h42);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      dbg = 8'(8'h50 + i);
      tick();
    end
    do_write(2'd1, 64'h1F);
    check("t6 enables set", 64'(pwe), 64'h1F);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6 enables reset", 64'(pwe), 64'h00);
    do_read(2'd2, v); check("t6 status reset", v, 64'h0000_0000_0001_0000);
    do_read(2'd0, v);
    check("t6 seq restart", 64'(v[38:32]), 64'd0);
    check("t6 dbg", 64'(v[7:0]), 64'h54);

    // Corner cases: capture+read on empty, clear+drop, flush+capture, read+write
    addr = 2'd0; rd = 1'b1; dbg = 8'h61;
    #3 v = rdata;
    tick();
    rd = 1'b0; addr = 2'd2;
    check("t7 no bypass", v, 64'd0);
    do_read(2'd2, v); check("t7 stored", 64'(v[15:0]), 64'd1);
    do_read(2'd0, v);
    for (int i = 0; i < 16; i++) begin
      dbg = 8'(8'h80 + i);
      tick();
    end
    addr = 2'd3; wr = 1'b1; wd = 64'h9; dbg = 8'hA0;
    tick();
    wr = 1'b0; wd = '0; addr = 2'd2;
    do_read(2'd2, v); check("t7 drop beats clear", v, 64'h0000_0001_0006_0010);
    addr = 2'd3; wr = 1'b1; wd = 64'h5; dbg = 8'hA1;
    tick();
    wr = 1'b0; wd = '0; addr = 2'd2;
    do_read(2'd2, v); check("t7 flush beats capture", v, 64'h0000_0001_0005_0000);
    addr = 2'd1; rd = 1'b1; wr = 1'b1; wd = 64'h3;
    #3 v = rdata;
    tick();
    rd = 1'b0; wr = 1'b0; wd = '0; addr = 2'd2;
    check("t7 rw old value", v, 64'h0);
    check("t7 rw new enables", 64'(pwe), 64'h3);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
